// File: rtl/pixel_scan_host_if.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scan_host_if
// Purpose  : Control, ray-pipeline and framebuffer signals of pixel_scan_host.
//            frame_checksum exists only when PIXEL_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface pixel_scan_host_if #(
    parameter int COL_W   = 7,
    parameter int ROW_W   = 6,
    parameter int COLOR_W = 12
);
    logic               start;
    logic               continuous;
    logic               issue_valid;
    logic [COL_W-1:0]   issue_col;
    logic [ROW_W-1:0]   issue_row;
    logic [COLOR_W-1:0] res_color;
    logic               res_collision;
    logic               wr_valid;
    logic               wr_ready;
    logic [COL_W-1:0]   wr_col;
    logic [ROW_W-1:0]   wr_row;
    logic [COLOR_W-1:0] wr_data;
    logic [3:0]         collision_sig;
    logic               frame_done;
    logic               busy;
`ifdef PIXEL_CHECKSUM_EN
    logic [15:0]        frame_checksum;
`endif

    modport master (
        input  start, continuous, res_color, res_collision, wr_ready,
        output issue_valid, issue_col, issue_row, wr_valid, wr_col, wr_row,
        output wr_data, collision_sig, frame_done, busy
`ifdef PIXEL_CHECKSUM_EN
        , output frame_checksum
`endif
    );

    modport slave (
        output start, continuous, res_color, res_collision, wr_ready,
        input  issue_valid, issue_col, issue_row, wr_valid, wr_col, wr_row,
        input  wr_data, collision_sig, frame_done, busy
`ifdef PIXEL_CHECKSUM_EN
        , input frame_checksum
`endif
    );
endinterface
`default_nettype wire

// File: rtl/pixel_scan_host.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scan_host
// Purpose  : Raster-order coordinate issuer for a fixed-latency ray pipeline,
//            re-tagging results into a credit-throttled output FIFO.
//            Optional PIXEL_CHECKSUM_EN adds a per-frame sum of written colours.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_scan_host #(
    parameter int COLS           = 80,
    parameter int ROWS           = 60,
    parameter int COL_W          = 7,
    parameter int ROW_W          = 6,
    parameter int COLOR_W        = 12,
    parameter int PIPE_LATENCY   = 7,
    parameter int ISSUE_INTERVAL = 7,
    parameter int FIFO_DEPTH     = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    pixel_scan_host_if.master bus
);
    localparam int c_aw    = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(PIPE_LATENCY + FIFO_DEPTH + 2) + 1;
    localparam int c_ivl_w = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
    localparam int c_ent_w = ROW_W + COL_W + COLOR_W;
    localparam logic [c_ivl_w-1:0] c_ivl_load = c_ivl_w'(ISSUE_INTERVAL - 1);
    localparam logic [COL_W-1:0]   c_last_col = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]   c_last_row = ROW_W'(ROWS - 1);
    localparam logic [c_aw:0]      c_depth    = (c_aw + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    logic               r_last_issued;
    logic [c_ivl_w-1:0] r_ivl;
    logic               r_issue_valid;
    logic [COL_W-1:0]   r_issue_col;
    logic [ROW_W-1:0]   r_issue_row;
    logic [3:0]         r_acc;
    logic [3:0]         r_sig;
    logic               r_frame_done;

    logic [PIPE_LATENCY-1:0] r_tag_vld;
    logic [COL_W-1:0]        r_tag_col [PIPE_LATENCY];
    logic [ROW_W-1:0]        r_tag_row [PIPE_LATENCY];

    logic [c_ent_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]    r_wptr;
    logic [c_aw-1:0]    r_rptr;
    logic [c_aw:0]      r_count;

    logic               w_tap_vld;
    logic [COL_W-1:0]   w_tap_col;
    logic [ROW_W-1:0]   w_tap_row;
    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic [c_ent_w-1:0] w_head;
    logic [c_cnt_w-1:0] w_in_flight;
    logic               w_credit;
    logic               w_start_scan;
    logic               w_issue;
    logic               w_drained;

    assign w_tap_vld = r_tag_vld[PIPE_LATENCY-1];
    assign w_tap_col = r_tag_col[PIPE_LATENCY-1];
    assign w_tap_row = r_tag_row[PIPE_LATENCY-1];
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_push    = w_tap_vld;
    assign w_pop     = !w_empty && bus.wr_ready;
    assign w_head    = w_empty ? '0 : r_mem[r_rptr];

    // The registered issue slot counts as in flight: it enters the tag line next edge.
    always_comb begin
        w_in_flight = c_cnt_w'(r_issue_valid);
        for (int i = 0; i < PIPE_LATENCY; i++) begin
            w_in_flight = w_in_flight + c_cnt_w'(r_tag_vld[i]);
        end
    end

    assign w_credit     = (w_in_flight + c_cnt_w'(r_count)) < c_cnt_w'(FIFO_DEPTH);
    assign w_start_scan = ((r_state == S_IDLE) && (bus.start || bus.continuous)) ||
                          ((r_state == S_DONE) && bus.continuous);
    assign w_issue      = (r_state == S_SCAN) && (r_ivl == '0) && w_credit && !r_last_issued;
    assign w_drained    = (w_in_flight == '0) && w_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_col         <= '0;
            r_row         <= '0;
            r_last_issued <= 1'b0;
            r_ivl         <= '0;
            r_issue_valid <= 1'b0;
            r_issue_col   <= '0;
            r_issue_row   <= '0;
            r_acc         <= '0;
            r_sig         <= 4'hF;
            r_frame_done  <= 1'b0;
        end else begin
            r_issue_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            if (r_ivl != '0) r_ivl <= r_ivl - 1'b1;
            if (w_tap_vld && bus.res_collision) begin
                r_acc[1] <= 1'b1;
                if (w_tap_col == '0)         r_acc[3] <= 1'b1;
                if (w_tap_col == c_last_col) r_acc[2] <= 1'b1;
                if (w_tap_row == '0)         r_acc[0] <= 1'b1;
            end
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    // Pixel (0,0) goes out on the first SCAN cycle itself.
                    if (w_start_scan) begin
                        r_state       <= S_SCAN;
                        r_issue_valid <= 1'b1;
                        r_issue_col   <= '0;
                        r_issue_row   <= '0;
                        r_col         <= COL_W'(1);
                        r_row         <= '0;
                        r_last_issued <= 1'b0;
                        r_ivl         <= c_ivl_load;
                        r_acc         <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SCAN: begin
                    if (r_last_issued) begin
                        r_state <= S_DRAIN;
                    end else if (w_issue) begin
                        r_issue_valid <= 1'b1;
                        r_issue_col   <= r_col;
                        r_issue_row   <= r_row;
                        r_ivl         <= c_ivl_load;
                        if (r_col == c_last_col) begin
                            r_col <= '0;
                            if (r_row == c_last_row) r_last_issued <= 1'b1;
                            else                     r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    // Summary is latched here so it is valid alongside frame_done.
                    if (w_drained) begin
                        r_state      <= S_DONE;
                        r_frame_done <= 1'b1;
                        r_sig        <= r_acc;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_vld <= '0;
            for (int i = 0; i < PIPE_LATENCY; i++) begin
                r_tag_col[i] <= '0;
                r_tag_row[i] <= '0;
            end
        end else begin
            for (int i = PIPE_LATENCY - 1; i > 0; i--) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_col[i] <= r_tag_col[i-1];
                r_tag_row[i] <= r_tag_row[i-1];
            end
            r_tag_vld[0] <= r_issue_valid;
            r_tag_col[0] <= r_issue_col;
            r_tag_row[0] <= r_issue_row;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_tap_row, w_tap_col, bus.res_color};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    assign bus.issue_valid   = r_issue_valid;
    assign bus.issue_col     = r_issue_col;
    assign bus.issue_row     = r_issue_row;
    assign bus.wr_valid      = !w_empty;
    assign bus.wr_row        = w_head[c_ent_w-1 -: ROW_W];
    assign bus.wr_col        = w_head[COLOR_W +: COL_W];
    assign bus.wr_data       = w_head[COLOR_W-1:0];
    assign bus.collision_sig = r_sig;
    assign bus.frame_done    = r_frame_done;
    assign bus.busy          = (r_state != S_IDLE);

`ifdef PIXEL_CHECKSUM_EN
    logic [15:0] r_sum;
    logic [15:0] r_checksum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum      <= '0;
            r_checksum <= '0;
        end else begin
            if (w_start_scan) r_sum <= '0;
            else if (w_pop)   r_sum <= r_sum + 16'(w_head[COLOR_W-1:0]);
            if ((r_state == S_DRAIN) && w_drained) r_checksum <= r_sum;
        end
    end

    assign bus.frame_checksum = r_checksum;
`endif
endmodule
`default_nettype wire
